addsub_chunked: RTL and testbench

//   Parametrised multi-cycle adder/subtractor for the ALU datapath.
//   - Processes a WIDTH-bit operation CHUNK bits per cycle through a ripple-carry chunk adder.
//   - Carry is registered between chunks, so a wide add costs cycles rather than combinational depth.
//   - Reports carry-out, signed overflow and zero.
//   - Uses a valid/ready handshake on both sides.

---
 rtl/addsub_chunked.sv | 179 +++++++++++++++++
 tb/tb_addsub_chunked.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_chunked.sv
// ---------------------------------------------------------------------------
// addsub_chunked
//   Multi-cycle adder/subtractor. A WIDTH-bit add or subtract is done CHUNK
//   bits per clock through a small ripple-carry adder. The carry between
//   chunks is registered, so the combinational depth stays at one chunk.
//   It reports carry-out, signed overflow and zero, and uses a valid/ready
//   handshake on both the operand side and the result side.
//
// Parameters
//   WIDTH      operand/result width, must be a multiple of CHUNK
//   CHUNK      bits added per RUN cycle (NCHUNK = WIDTH/CHUNK >= 1)
//
// Ports
//   clk        clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       operands
//   sub        0: a+b, 1: a-b
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   sum        result
//   cout       carry out of MSB (for subtract, 1 means no borrow)
//   overflow   signed overflow
//   zero       sum == 0
//
// Optional feature (macro SAT_EN)
//   When defined, a signed overflow clamps sum to the most positive or most
//   negative value. overflow and cout still describe the raw result, and
//   zero describes the clamped sum. When undefined, sum wraps and there is
//   no clamp logic.
// ---------------------------------------------------------------------------
module addsub_chunked #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              overflow_q, overflow_d;
  logic              zero_q, zero_d;

  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK:0]    chunk_res;
  logic [WIDTH-1:0]  merged;
  logic              raw_ovf;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    // One chunk of the ripple adder, with the stored inter-chunk carry.
    a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
    b_chunk   = b_q[idx_q*CHUNK +: CHUNK];
    chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

    merged = sum_q;
    merged[idx_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];

    // b_q already holds the effective (possibly inverted) operand, so the
    // sign rule below is equivalent to carry-into-MSB XOR carry-out-of-MSB
    // and also works when a chunk is a single bit.
    raw_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (merged[WIDTH-1] != a_q[WIDTH-1]);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1: invert b here, inject 1 as carry-in.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        sum_d   = merged;
        carry_d = chunk_res[CHUNK];
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          idx_d      = '0;
          cout_d     = chunk_res[CHUNK];
          overflow_d = raw_ovf;
          zero_d     = (merged == '0);
`ifdef SAT_EN
          // A raw MSB of 1 after overflow means the true result was too
          // positive; a raw MSB of 0 means it was too negative.
          if (raw_ovf) begin
            sum_d  = merged[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                     : {1'b1, {(WIDTH-1){1'b0}}};
            zero_d = 1'b0;
          end
`endif
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

endmodule

// File: tb/tb_addsub_chunked.sv
module tb_addsub_chunked;

  localparam int NCHUNK = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;
  logic        zero;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        sub8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  sum8;
  logic        cout8;
  logic        overflow8;
  logic        zero8;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  addsub_chunked #(.WIDTH(32), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  addsub_chunked #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .sub       (sub8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8),
    .overflow  (overflow8),
    .zero      (zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one operation. When expect_result is set, the expected response is
  // queued for the monitor and the accept-to-out_valid latency is checked.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                               input logic [31:0] esum, input logic ecout, input logic eovf,
                               input logic ezero, input string name, input bit expect_result);
    exp_t e;
    int   n;
    bit   ready_seen;
    ready_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ready_seen = 1'b1;
        break;
      end
    end
    if (!ready_seen) checkOutput({name, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
    if (expect_result) begin
      e.sum = esum; e.cout = ecout; e.ovf = eovf; e.zero = ezero; e.name = name;
      sb_q.push_back(e);
    end
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (expect_result) begin
      n = 0;
      do begin
        @(posedge clk);
        #1 n++;
      end while (out_valid !== 1'b1 && n < 50);
      checkOutput({name, "_latency"}, 32'(n), 32'(NCHUNK));
    end
  endtask

  // Monitor: whenever a result is presented, compare it with the head of the
  // scoreboard; pop only when the consumer takes it, so a held result is
  // re-checked every cycle it is held.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_result", sum, 32'hDEAD_0000);
      end else begin
        checkOutput({sb_q[0].name, "_sum"},  sum,              sb_q[0].sum);
        checkOutput({sb_q[0].name, "_cout"}, 32'(cout),        32'(sb_q[0].cout));
        checkOutput({sb_q[0].name, "_ovf"},  32'(overflow),    32'(sb_q[0].ovf));
        checkOutput({sb_q[0].name, "_zero"}, 32'(zero),        32'(sb_q[0].zero));
        if (out_ready === 1'b1) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n8;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; out_ready8 = 1'b1;

    #12;
    checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_sum",       sum,            32'd0);
    checkOutput("reset_flags",     {29'd0, cout, overflow, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "wrap", 1'b1);
`ifdef SAT_EN
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, "pos_ovf", 1'b1);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, "neg_ovf_sub", 1'b1);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, "neg_ovf_add", 1'b1);
`else
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "pos_ovf", 1'b1);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, "neg_ovf_sub", 1'b1);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, "neg_ovf_add", 1'b1);
`endif
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "sub_borrow", 1'b1);
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, "plain_add", 1'b1);
    applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "sub_equal", 1'b1);

    // Backpressure: hold the result for 5 cycles while offering new operands.
    @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, "bp_held", 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; in_valid = 1'b1;
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    applyStimulus(32'd100, 32'd200, 1'b1, 32'hFFFF_FF9C, 1'b0, 1'b0, 1'b0, "after_bp", 1'b1);

    // Reset in the middle of RUN (after three chunks have been processed).
    applyStimulus(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "aborted", 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_in_ready",  32'(in_ready),  32'd1);
    checkOutput("abort_sum",       sum,            32'd0);
    checkOutput("abort_flags",     {29'd0, cout, overflow, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0, "post_reset", 1'b1);

    // Single-chunk instance: one RUN cycle.
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    n8 = 0;
    do begin
      @(posedge clk);
      #1 n8++;
    end while (out_valid8 !== 1'b1 && n8 < 20);
    checkOutput("w8_latency", 32'(n8), 32'd1);
`ifdef SAT_EN
    checkOutput("w8_sum", 32'(sum8), 32'h7F);
`else
    checkOutput("w8_sum", 32'(sum8), 32'h80);
`endif
    checkOutput("w8_ovf",  32'(overflow8), 32'd1);
    checkOutput("w8_cout", 32'(cout8),     32'd0);
    checkOutput("w8_zero", 32'(zero8),     32'd0);

    repeat (4) @(posedge clk);
    #1 checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
